// File: rtl/hack_addn_seq.sv
// Multi-cycle adder/subtractor for the Hack datapath. It processes DIGIT bits per clock and
// ripples the carry between cycles. Results and flags are published only when an operation completes.
module hack_addn_seq #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             ovf,
  output logic             zr,
  output logic             ng
);

  localparam int S     = WIDTH / DIGIT;
  localparam int CNT_W = (S > 1) ? $clog2(S) : 1;

  generate
    if (WIDTH < 2) begin : g_bad_width
      $error("hack_addn_seq: WIDTH must be at least 2");
    end
    if ((DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_bad_digit
      $error("hack_addn_seq: WIDTH must be a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cin_q, cin_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic               carry_q, carry_d;
  logic               ovf_q, ovf_d;
  logic               zr_q, zr_d;
  logic               ng_q, ng_d;

  logic [DIGIT:0]       dsum;
  logic [WIDTH+DIGIT-1:0] res_shift;
  logic                 last;

  function automatic logic [DIGIT:0] digit_add(input logic [DIGIT-1:0] x,
                                               input logic [DIGIT-1:0] y,
                                               input logic             ci);
    return {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, ci};
  endfunction

  // Operands shift right each cycle, so the active digit always sits in the low DIGIT bits.
  assign dsum      = digit_add(a_q[DIGIT-1:0], b_q[DIGIT-1:0], cin_q);
  assign res_shift = {dsum[DIGIT-1:0], res_q};
  assign last      = (cnt_q == CNT_W'(S - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    cin_d   = cin_q;
    done_d  = 1'b0;
    out_d   = out_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    zr_d    = zr_q;
    ng_d    = ng_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          cin_d   = sub;
          cnt_d   = '0;
          res_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = a_q >> DIGIT;
        b_d   = b_q >> DIGIT;
        cin_d = dsum[DIGIT];
        res_d = res_shift[WIDTH+DIGIT-1:DIGIT];
        cnt_d = cnt_q + CNT_W'(1);
        if (last) begin
          // The final digit holds both operand MSBs, which determine signed overflow.
          state_d = IDLE;
          done_d  = 1'b1;
          cnt_d   = '0;
          out_d   = res_d;
          carry_d = dsum[DIGIT];
          ovf_d   = (a_q[DIGIT-1] == b_q[DIGIT-1]) && (dsum[DIGIT-1] != a_q[DIGIT-1]);
          zr_d    = (res_d == '0);
          ng_d    = res_d[WIDTH-1];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      cin_q   <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zr_q    <= 1'b1;
      ng_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      cin_q   <= cin_d;
      done_q  <= done_d;
      out_q   <= out_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      zr_q    <= zr_d;
      ng_q    <= ng_d;
    end
  end

  assign busy  = (state_q == RUN);
  assign done  = done_q;
  assign out   = out_q;
  assign carry = carry_q;
  assign ovf   = ovf_q;
  assign zr    = zr_q;
  assign ng    = ng_q;

endmodule

// File: tb/tb_hack_addn_seq.sv
// Directed bench for hack_addn_seq (WIDTH=16, DIGIT=4). A FIFO scoreboard is filled when an
// operation is launched and drained on each done pulse.
module tb_hack_addn_seq;

  localparam int W = 16;
  localparam int D = 4;
  localparam int S = W / D;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, carry, ovf, zr, ng;
  logic [W-1:0] out;

  hack_addn_seq #(.WIDTH(W), .DIGIT(D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .out(out), .carry(carry), .ovf(ovf), .zr(zr), .ng(ng)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] out;
    logic         c;
    logic         v;
    logic         z;
    logic         n;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference derived from integer arithmetic: signed range for overflow, magnitude for carry.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    exp_t e;
    int   sx, sy, r;
    int   ux, uy, ur;
    sx = int'($signed(x));
    sy = int'($signed(y));
    ux = int'(x);
    uy = int'(y);
    r  = s ? (sx - sy) : (sx + sy);
    ur = s ? (ux - uy) : (ux + uy);
    e.out = W'(ur);
    e.c   = s ? (ux >= uy) : (ur > 32'hFFFF);
    e.v   = (r > 32767) || (r < -32768);
    e.z   = (W'(ur) == '0);
    e.n   = ur[W-1];
    return e;
  endfunction

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
    n_tests++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      n_tests++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL spurious_done: observed done=1 with no operation outstanding expected done=0");
      end
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("sb_out",   out,      mon_e.out);
        check("sb_carry", W'(carry), W'(mon_e.c));
        check("sb_ovf",   W'(ovf),   W'(mon_e.v));
        check("sb_zr",    W'(zr),    W'(mon_e.z));
        check("sb_ng",    W'(ng),    W'(mon_e.n));
      end
    end
  end

  task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                        input bit expect_done);
    a     = x;
    b     = y;
    sub   = s;
    start = 1'b1;
    if (expect_done) sb.push_back(model(x, y, s));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", W'(busy), W'(1));
  endtask

  task automatic wait_done(input int pre, input logic [W-1:0] want, input string tag);
    int cyc;
    cyc = pre;
    do begin
      @(negedge clk);
      cyc++;
    end while (done !== 1'b1 && cyc < 20);
    check({tag, "_latency"}, W'(cyc), W'(S));
    check({tag, "_out"}, out, want);
    check({tag, "_busy"}, W'(busy), W'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int spurious;

    repeat (2) @(negedge clk);
    check("t1_rst_out",  out,      16'h0000);
    check("t1_rst_zr",   W'(zr),   W'(1));
    check("t1_rst_busy", W'(busy), W'(0));
    check("t1_rst_done", W'(done), W'(0));
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("t1_idle_out",  out,      16'h0000);
    check("t1_idle_zr",   W'(zr),   W'(1));
    check("t1_idle_busy", W'(busy), W'(0));
    check("t1_idle_done", W'(done), W'(0));

    launch(16'h0000, 16'hFFFF, 1'b0, 1'b1);
    wait_done(0, 16'hFFFF, "t2");
    @(negedge clk);
    check("t2_done_pulse", W'(done), W'(0));

    launch(16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
    wait_done(0, 16'hFFFE, "t3");

    launch(16'hAAAA, 16'h5555, 1'b0, 1'b1);
    wait_done(0, 16'hFFFF, "t4a");
    launch(16'h1234, 16'h9876, 1'b0, 1'b1);
    wait_done(0, 16'hAAAA, "t4b");
    launch(16'h7FFF, 16'h0001, 1'b0, 1'b1);
    wait_done(0, 16'h8000, "t4c");

    launch(16'h0005, 16'h0007, 1'b1, 1'b1);
    wait_done(0, 16'hFFFE, "t5a");
    launch(16'h0007, 16'h0007, 1'b1, 1'b1);
    wait_done(0, 16'h0000, "t5b");

    launch(16'h3C3C, 16'h0FF0, 1'b0, 1'b1);
    @(negedge clk);
    check("t6_hold_out", out, 16'h0000);
    a     = 16'hFFFF;
    b     = 16'hFFFF;
    sub   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t6_hold_busy", W'(busy), W'(1));
    wait_done(2, 16'h4C2C, "t6_ignore");

    launch(16'h1111, 16'h2222, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_abort_out",   out,       16'h0000);
    check("t6_abort_zr",    W'(zr),    W'(1));
    check("t6_abort_ng",    W'(ng),    W'(0));
    check("t6_abort_carry", W'(carry), W'(0));
    check("t6_abort_ovf",   W'(ovf),   W'(0));
    check("t6_abort_busy",  W'(busy),  W'(0));
    check("t6_abort_done",  W'(done),  W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    spurious = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done === 1'b1) spurious++;
    end
    check("t6_abort_no_done", W'(spurious), W'(0));

    launch(16'h0001, 16'h0001, 1'b0, 1'b1);
    wait_done(0, 16'h0002, "post_reset");
    repeat (2) @(negedge clk);
    check("sb_drained", W'(sb.size()), W'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
